// File: rtl/alu_muldiv.sv
// alu_muldiv: MIPS execute-stage ALU with an iterative multiply/divide unit.
//
// Single-cycle operations (AND, OR, ADD, SUB, SLT, SLTU, NOR, MFHI, MFLO) are
// purely combinational on Result. MULT/MULTU/DIV/DIVU are launched with start,
// take WIDTH steps, and land in the HI/LO registers with a one-cycle done pulse.
//
// Optional feature macro: ALU_DIV_EN
//   defined   -> DIV/DIVU supported (restoring divider shares the HI/LO datapath)
//   undefined -> divider omitted, divide starts ignored, div_by_zero tied 0
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   A, B         operands (rs, rt/immediate)
//   ALUControl   operation select
//   start        launch a multi-cycle op (codes 1000-1011)
//   Result       combinational result, Zero flags Result == 0
//   busy         multi-cycle op in progress
//   done         one-cycle pulse after HI/LO were written
//   hi, lo       HI/LO registers
//   div_by_zero  last divide had a zero divisor, held until next accepted start

module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUControl,
  input  logic             start,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   accHi_q, accLo_q, opB_q, hi_q, lo_q;
  logic               negA_q, negB_q, busy_q, done_q;
  logic [WIDTH-1:0]   stepHi_d, stepLo_d, finalHi_d, finalLo_d;
  logic               isMul, opSigned, accept;
  logic [WIDTH-1:0]   absA, absB;
  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] prod;

`ifdef ALU_DIV_EN
  logic               isDiv, opDiv_q, dbz_q;
  logic [WIDTH:0]     divShift, divDiff;
  logic [WIDTH-1:0]   quo, rem;
`endif

  // Single-cycle result path; MFHI/MFLO read the committed registers, so
  // they return the previous values while an op is still running.
  always_comb begin
    Result = '0;
    case (ALUControl)
      4'b0000: Result = A & B;
      4'b0001: Result = A | B;
      4'b0010: Result = A + B;
      4'b0110: Result = A - B;
      4'b0111: Result = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      4'b0011: Result = {{(WIDTH-1){1'b0}}, (A < B)};
      4'b1100: Result = ~(A | B);
      4'b1101: Result = hi_q;
      4'b1110: Result = lo_q;
      default: Result = '0;
    endcase
  end

  assign Zero = (Result == '0);

  // Even codes of the 100x/101x group are the signed variants.
  assign isMul    = (ALUControl[3:1] == 3'b100);
  assign opSigned = ~ALUControl[0];
  assign absA     = (opSigned && A[WIDTH-1]) ? -A : A;
  assign absB     = (opSigned && B[WIDTH-1]) ? -B : B;

`ifdef ALU_DIV_EN
  assign isDiv  = (ALUControl[3:1] == 3'b101);
  assign accept = start && (isMul || isDiv);
`else
  assign accept = start && isMul;
`endif

  // One iteration of the shared HI/LO datapath plus the sign fix-up applied
  // on the final step. Multiply: accLo holds the shifting multiplier, accHi
  // the partial sum. Divide: accLo shifts the dividend out and quotient bits
  // in, accHi holds the running remainder.
  always_comb begin
    mulSum    = {1'b0, accHi_q} + {1'b0, (accLo_q[0] ? opB_q : {WIDTH{1'b0}})};
    stepHi_d  = mulSum[WIDTH:1];
    stepLo_d  = {mulSum[0], accLo_q[WIDTH-1:1]};
    prod      = {stepHi_d, stepLo_d};
    if (negA_q ^ negB_q) prod = -prod;
    finalHi_d = prod[2*WIDTH-1:WIDTH];
    finalLo_d = prod[WIDTH-1:0];
`ifdef ALU_DIV_EN
    divShift = {accHi_q, accLo_q[WIDTH-1]};
    divDiff  = divShift - {1'b0, opB_q};
    quo      = '0;
    rem      = '0;
    if (opDiv_q) begin
      // Top bit of the difference is the borrow: set means restore.
      if (!divDiff[WIDTH]) begin
        stepHi_d = divDiff[WIDTH-1:0];
        stepLo_d = {accLo_q[WIDTH-2:0], 1'b1};
      end else begin
        stepHi_d = divShift[WIDTH-1:0];
        stepLo_d = {accLo_q[WIDTH-2:0], 1'b0};
      end
      quo = (negA_q ^ negB_q) ? -stepLo_d : stepLo_d;
      rem = negA_q ? -stepHi_d : stepHi_d;
      // A zero divisor naturally leaves |A| as remainder, which the sign
      // fix-up turns back into A; only the quotient needs forcing.
      finalHi_d = rem;
      finalLo_d = (opB_q == '0) ? '1 : quo;
    end
`endif
  end

  // Control FSM with registered busy/done and the HI/LO commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      accHi_q <= '0;
      accLo_q <= '0;
      opB_q   <= '0;
      negA_q  <= 1'b0;
      negB_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef ALU_DIV_EN
      opDiv_q <= 1'b0;
      dbz_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (accept) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            accHi_q <= '0;
            negA_q  <= opSigned && A[WIDTH-1];
            negB_q  <= opSigned && B[WIDTH-1];
            if (isMul) begin
              accLo_q <= absB;
              opB_q   <= absA;
            end else begin
              accLo_q <= absA;
              opB_q   <= absB;
            end
`ifdef ALU_DIV_EN
            opDiv_q <= ~isMul;
            dbz_q   <= 1'b0;
`endif
          end
        end
        RUN: begin
          accHi_q <= stepHi_d;
          accLo_q <= stepLo_d;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH-1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            hi_q    <= finalHi_d;
            lo_q    <= finalLo_d;
`ifdef ALU_DIV_EN
            dbz_q   <= opDiv_q && (opB_q == '0);
`endif
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
`ifdef ALU_DIV_EN
  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: self-checking bench for alu_muldiv (WIDTH=32).
// Expected values come from a behavioural model using 64-bit integer
// arithmetic; HI/LO/div_by_zero are tracked in the model across tests.

module tb_alu_muldiv;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] A, B;
  logic [3:0]   ALUControl;
  logic         start;
  logic [W-1:0] Result, hi, lo;
  logic         Zero, busy, done, div_by_zero;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] modelHi  = '0;
  logic [W-1:0] modelLo  = '0;
  logic         modelDbz = 1'b0;

  alu_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .ALUControl(ALUControl),
    .start(start), .Result(Result), .Zero(Zero), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  // Free-running clock, 10 ns period.
  always #5 clk = ~clk;

  // Reference for the single-cycle operations.
  function automatic logic [W-1:0] refAlu(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [3:0] code,
                                           input logic [W-1:0] h, input logic [W-1:0] l);
    case (code)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: return (a < b) ? 32'd1 : 32'd0;
      4'b1100: return ~(a | b);
      4'b1101: return h;
      4'b1110: return l;
      default: return '0;
    endcase
  endfunction

  // Reference for the multi-cycle operations using wide integer arithmetic.
  function automatic void refMulDiv(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic [3:0] code,
                                    output logic [W-1:0] h, output logic [W-1:0] l,
                                    output logic z);
    longint       sa, sb, q, r;
    logic [63:0]  up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    h = modelHi;
    l = modelLo;
    z = modelDbz;
    case (code)
      4'b1000: begin q = sa * sb; h = q[63:32]; l = q[31:0]; z = 1'b0; end
      4'b1001: begin up = {32'b0, a} * {32'b0, b}; h = up[63:32]; l = up[31:0]; z = 1'b0; end
      4'b1010, 4'b1011: begin
        if (b == '0) begin
          l = '1; h = a; z = 1'b1;
        end else if (code == 4'b1010) begin
          q = sa / sb; r = sa % sb; l = q[31:0]; h = r[31:0]; z = 1'b0;
        end else begin
          l = a / b; h = a % b; z = 1'b0;
        end
      end
      default: ;
    endcase
  endfunction

  // Drives inputs for a single-cycle operation (start low).
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] code);
    @(negedge clk);
    A = a; B = b; ALUControl = code; start = 1'b0;
    #1;
  endtask

  // Launches a multi-cycle op and observes busy/done over a bounded window.
  // Operands are scrambled while running; optionally a second start is
  // thrown in at RUN cycle 5.
  task automatic issueOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] code,
                         input bit disturb, output int busyCycles, output int doneCount);
    busyCycles = 0;
    doneCount  = 0;
    @(negedge clk);
    A = a; B = b; ALUControl = code; start = 1'b1;
    @(negedge clk);
    start = 1'b0; ALUControl = 4'b0000;
    for (int c = 0; c < W + 6; c++) begin
      if (busy === 1'b1) busyCycles++;
      if (done === 1'b1) doneCount++;
      A = $urandom; B = $urandom;
      if (disturb && c == 4) begin
        start = 1'b1; ALUControl = 4'b1001;
      end else begin
        start = 1'b0; ALUControl = 4'b0000;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; A = '0; B = '0; ALUControl = 4'b0000;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if (hi !== '0) begin failures++; $display("[TB] FAIL reset_hi: got %h expected 0", hi); end
    checks++; if (lo !== '0) begin failures++; $display("[TB] FAIL reset_lo: got %h expected 0", lo); end
    checks++; if (div_by_zero !== 1'b0) begin failures++; $display("[TB] FAIL reset_dbz: got %b expected 0", div_by_zero); end
    reset = 1'b0;
    modelHi = '0; modelLo = '0; modelDbz = 1'b0;
  endtask

  task automatic test_comb(input int nRandom);
    logic [W-1:0] a, b, exp;
    logic [3:0]   code;
    applyStimulus(32'hFFFFFFFF, 32'h1, 4'b0111);
    checks++; if (Result !== 32'h1) begin failures++; $display("[TB] FAIL slt_neg: got %h expected 00000001", Result); end
    applyStimulus(32'hFFFFFFFF, 32'h1, 4'b0011);
    checks++; if (Result !== 32'h0) begin failures++; $display("[TB] FAIL sltu: got %h expected 00000000", Result); end
    checks++; if (Zero !== 1'b1) begin failures++; $display("[TB] FAIL sltu_zero: got %b expected 1", Zero); end
    for (int i = 0; i < nRandom; i++) begin
      a = $urandom; b = $urandom;
      if (i % 5 == 0) b = a;
      code = 4'($urandom_range(0, 15));
      exp = refAlu(a, b, code, modelHi, modelLo);
      applyStimulus(a, b, code);
      checks++; if (Result !== exp) begin failures++; $display("[TB] FAIL comb_result code=%b: got %h expected %h", code, Result, exp); end
      checks++; if (Zero !== (exp == '0)) begin failures++; $display("[TB] FAIL comb_zero code=%b: got %b expected %b", code, Zero, (exp == '0)); end
    end
    // start with a single-cycle code must not launch anything
    @(negedge clk);
    A = 32'd5; B = 32'd6; ALUControl = 4'b0010; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("[TB] FAIL ignored_start: got busy=%b done=%b expected 0/0", busy, done); end
  endtask

  task automatic test_mult(input int n);
    logic [W-1:0] a, b, eh, el;
    logic         ez;
    logic [3:0]   code;
    int           bc, dc;
    for (int i = 0; i < n; i++) begin
      if (i == 0) begin a = 32'hFFFFFFFE; b = 32'd3; code = 4'b1000; end
      else if (i == 1) begin a = 32'h80000000; b = 32'h80000000; code = 4'b1000; end
      else begin a = $urandom; b = $urandom; code = 4'b1000 | 4'($urandom_range(0, 1)); end
      refMulDiv(a, b, code, eh, el, ez);
      issueOp(a, b, code, 1'b0, bc, dc);
      checks++; if (bc !== W) begin failures++; $display("[TB] FAIL mult_busy_cycles: got %0d expected %0d", bc, W); end
      checks++; if (dc !== 1) begin failures++; $display("[TB] FAIL mult_done_count: got %0d expected 1", dc); end
      checks++; if (hi !== eh) begin failures++; $display("[TB] FAIL mult_hi a=%h b=%h code=%b: got %h expected %h", a, b, code, hi, eh); end
      checks++; if (lo !== el) begin failures++; $display("[TB] FAIL mult_lo a=%h b=%h code=%b: got %h expected %h", a, b, code, lo, el); end
      modelHi = eh; modelLo = el; modelDbz = ez;
    end
  endtask

`ifdef ALU_DIV_EN
  task automatic test_div(input int n);
    logic [W-1:0] a, b, eh, el;
    logic         ez, seen;
    logic [3:0]   code;
    int           bc, dc, pick;
    for (int i = 0; i < n; i++) begin
      if (i == 0) begin a = 32'hFFFFFFF9; b = 32'd2; code = 4'b1010; end
      else if (i == 1) begin a = 32'd7; b = 32'd0; code = 4'b1011; end
      else if (i == 2) begin a = 32'h80000000; b = 32'hFFFFFFFF; code = 4'b1010; end
      else if (i == 3) begin a = 32'hFFFFFFF7; b = 32'd0; code = 4'b1010; end
      else begin
        a = $urandom;
        pick = $urandom_range(0, 3);
        if (pick == 0) b = '0;
        else if (pick == 1) b = 32'($urandom_range(1, 20)) * (($urandom_range(0, 1) == 1) ? 32'hFFFFFFFF : 32'd1);
        else b = $urandom;
        code = 4'b1010 | 4'($urandom_range(0, 1));
      end
      refMulDiv(a, b, code, eh, el, ez);
      issueOp(a, b, code, 1'b0, bc, dc);
      checks++; if (bc !== W) begin failures++; $display("[TB] FAIL div_busy_cycles: got %0d expected %0d", bc, W); end
      checks++; if (dc !== 1) begin failures++; $display("[TB] FAIL div_done_count: got %0d expected 1", dc); end
      checks++; if (hi !== eh) begin failures++; $display("[TB] FAIL div_hi a=%h b=%h code=%b: got %h expected %h", a, b, code, hi, eh); end
      checks++; if (lo !== el) begin failures++; $display("[TB] FAIL div_lo a=%h b=%h code=%b: got %h expected %h", a, b, code, lo, el); end
      checks++; if (div_by_zero !== ez) begin failures++; $display("[TB] FAIL div_dbz a=%h b=%h: got %b expected %b", a, b, div_by_zero, ez); end
      modelHi = eh; modelLo = el; modelDbz = ez;
    end
    // flag holds while idle and clears on the next accepted start
    refMulDiv(32'd5, 32'd0, 4'b1011, eh, el, ez);
    issueOp(32'd5, 32'd0, 4'b1011, 1'b0, bc, dc);
    modelHi = eh; modelLo = el; modelDbz = ez;
    repeat (3) @(negedge clk);
    checks++; if (div_by_zero !== 1'b1) begin failures++; $display("[TB] FAIL dbz_held: got %b expected 1", div_by_zero); end
    refMulDiv(32'd9, 32'd9, 4'b1001, eh, el, ez);
    @(negedge clk);
    A = 32'd9; B = 32'd9; ALUControl = 4'b1001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (div_by_zero !== 1'b0) begin failures++; $display("[TB] FAIL dbz_clear_on_start: got %b expected 0", div_by_zero); end
    seen = 1'b0;
    for (int c = 0; c < W + 6 && !seen; c++) begin
      @(negedge clk);
      seen = (done === 1'b1);
    end
    checks++; if (seen !== 1'b1) begin failures++; $display("[TB] FAIL dbz_clear_done_timeout: got %b expected 1", seen); end
    modelHi = eh; modelLo = el; modelDbz = ez;
    @(negedge clk);
  endtask
`else
  task automatic test_div(input int n);
    int bc, dc;
    for (int i = 0; i < n; i++) begin
      issueOp($urandom, $urandom, 4'b1010 | 4'(i % 2), 1'b0, bc, dc);
      checks++; if (bc !== 0) begin failures++; $display("[TB] FAIL nodiv_busy: got %0d expected 0", bc); end
      checks++; if (dc !== 0) begin failures++; $display("[TB] FAIL nodiv_done: got %0d expected 0", dc); end
      checks++; if (hi !== modelHi) begin failures++; $display("[TB] FAIL nodiv_hi: got %h expected %h", hi, modelHi); end
      checks++; if (lo !== modelLo) begin failures++; $display("[TB] FAIL nodiv_lo: got %h expected %h", lo, modelLo); end
      checks++; if (div_by_zero !== 1'b0) begin failures++; $display("[TB] FAIL nodiv_dbz: got %b expected 0", div_by_zero); end
    end
  endtask
`endif

  task automatic test_back_to_back();
    logic [W-1:0] a, b, eh, el;
    logic         ez;
    int           bc, dc;
    refMulDiv(32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1001, eh, el, ez);
    issueOp(32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1001, 1'b1, bc, dc);
    checks++; if (dc !== 1) begin failures++; $display("[TB] FAIL b2b_single_done: got %0d expected 1", dc); end
    checks++; if (bc !== W) begin failures++; $display("[TB] FAIL b2b_busy_cycles: got %0d expected %0d", bc, W); end
    checks++; if (hi !== 32'hFFFFFFFE) begin failures++; $display("[TB] FAIL b2b_hi: got %h expected FFFFFFFE", hi); end
    checks++; if (lo !== 32'h00000001) begin failures++; $display("[TB] FAIL b2b_lo: got %h expected 00000001", lo); end
    modelHi = eh; modelLo = el; modelDbz = ez;
    a = $urandom; b = $urandom;
    refMulDiv(a, b, 4'b1000, eh, el, ez);
    issueOp(a, b, 4'b1000, 1'b1, bc, dc);
    checks++; if (dc !== 1) begin failures++; $display("[TB] FAIL b2b2_done: got %0d expected 1", dc); end
    checks++; if (hi !== eh) begin failures++; $display("[TB] FAIL b2b2_hi: got %h expected %h", hi, eh); end
    checks++; if (lo !== el) begin failures++; $display("[TB] FAIL b2b2_lo: got %h expected %h", lo, el); end
    modelHi = eh; modelLo = el; modelDbz = ez;
  endtask

  task automatic test_mfhi_mflo();
    logic [W-1:0] a, b, eh, el;
    logic         ez, seen;
    a = $urandom | 32'h1; b = $urandom | 32'h2;
    refMulDiv(a, b, 4'b1000, eh, el, ez);
    @(negedge clk);
    A = a; B = b; ALUControl = 4'b1000; start = 1'b1;
    @(negedge clk);
    start = 1'b0; ALUControl = 4'b1110;
    #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL mf_busy: got %b expected 1", busy); end
    checks++; if (Result !== modelLo) begin failures++; $display("[TB] FAIL mflo_during_run: got %h expected %h", Result, modelLo); end
    ALUControl = 4'b1101;
    #1;
    checks++; if (Result !== modelHi) begin failures++; $display("[TB] FAIL mfhi_during_run: got %h expected %h", Result, modelHi); end
    seen = 1'b0;
    for (int c = 0; c < W + 6 && !seen; c++) begin
      @(negedge clk);
      seen = (done === 1'b1);
    end
    checks++; if (seen !== 1'b1) begin failures++; $display("[TB] FAIL mf_done_timeout: got %b expected 1", seen); end
    ALUControl = 4'b1110;
    #1;
    checks++; if (Result !== el) begin failures++; $display("[TB] FAIL mflo_after_done: got %h expected %h", Result, el); end
    ALUControl = 4'b1101;
    #1;
    checks++; if (Result !== eh) begin failures++; $display("[TB] FAIL mfhi_after_done: got %h expected %h", Result, eh); end
    modelHi = eh; modelLo = el; modelDbz = ez;
    @(negedge clk);
    ALUControl = 4'b0000;
  endtask

  task automatic test_reset_midrun();
    int doneCount;
    @(negedge clk);
    A = 32'h12345; B = 32'h6789; ALUControl = 4'b1001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    modelHi = '0; modelLo = '0; modelDbz = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL midrst_done: got %b expected 0", done); end
    checks++; if (hi !== '0) begin failures++; $display("[TB] FAIL midrst_hi: got %h expected 0", hi); end
    checks++; if (lo !== '0) begin failures++; $display("[TB] FAIL midrst_lo: got %h expected 0", lo); end
    checks++; if (div_by_zero !== 1'b0) begin failures++; $display("[TB] FAIL midrst_dbz: got %b expected 0", div_by_zero); end
    doneCount = 0;
    for (int c = 0; c < W + 6; c++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) doneCount++;
    end
    checks++; if (doneCount !== 0) begin failures++; $display("[TB] FAIL midrst_no_late_done: got %0d expected 0", doneCount); end
    checks++; if (lo !== '0) begin failures++; $display("[TB] FAIL midrst_lo_later: got %h expected 0", lo); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; A = '0; B = '0; ALUControl = 4'b0000;
    test_reset();
    test_comb(8);
    test_mult(8);
    test_comb(24);
    test_div(10);
    test_back_to_back();
    test_mfhi_mflo();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
